video_timing_generator: RTL and testbench

VIDEO_TIMING_GENERATOR -- requirements
Module: video_timing_generator

---
 rtl/video_timing_generator_pkg.sv | 25 ++
 rtl/video_timing_generator_sync_phase_counter.sv | 49 ++++
 rtl/video_timing_generator.sv | 75 +++++++
 tb/tb_video_timing_generator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_generator_pkg.sv
// Shared definitions for the video timing generator: phase encoding and 640x480 defaults.
package video_timing_defs;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    localparam int DEF_H_ACTIVE        = 640;
    localparam int DEF_H_FRONT_PORCH   = 16;
    localparam int DEF_H_SYNC_WIDTH    = 96;
    localparam int DEF_H_BACK_PORCH    = 48;
    localparam int DEF_V_ACTIVE        = 480;
    localparam int DEF_V_FRONT_PORCH   = 10;
    localparam int DEF_V_SYNC_WIDTH    = 2;
    localparam int DEF_V_BACK_PORCH    = 33;

    // Phases run in encoding order, so the successor is a 2-bit increment.
    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/video_timing_generator_sync_phase_counter.sv
// One timing axis: walks ACTIVE/FRONT/SYNC/BACK, counting cycles within each phase.
module sync_phase_counter
    import video_timing_defs::*;
#(
    parameter int active_len = 640,
    parameter int front_len  = 16,
    parameter int sync_len   = 96,
    parameter int back_len   = 48
) (
    input  logic        input_clock,
    input  logic        reset,
    input  logic        advance,
    output phase_t      phase,
    output logic [11:0] count,
    output logic        wrap
);

    logic [11:0] phase_len;
    logic        last;

    always_comb begin
        phase_len = 12'(active_len);
        case (phase)
            PH_ACTIVE: phase_len = 12'(active_len);
            PH_FRONT:  phase_len = 12'(front_len);
            PH_SYNC:   phase_len = 12'(sync_len);
            PH_BACK:   phase_len = 12'(back_len);
            default:   phase_len = 12'(active_len);
        endcase
    end

    assign last = (count == phase_len - 12'd1);
    assign wrap = advance && last && (phase == PH_BACK);

    always_ff @(posedge input_clock) begin
        if (!reset) begin
            phase <= PH_ACTIVE;
            count <= 12'd0;
        end else if (advance) begin
            if (last) begin
                phase <= next_phase(phase);
                count <= 12'd0;
            end else begin
                count <= count + 12'd1;
            end
        end
    end

endmodule

// File: rtl/video_timing_generator.sv
// Raster timing generator: horizontal and vertical phase counters plus registered sync/DE outputs.
module video_timing_generator
    import video_timing_defs::*;
#(
    parameter int h_active      = DEF_H_ACTIVE,
    parameter int h_front_porch = DEF_H_FRONT_PORCH,
    parameter int h_sync_width  = DEF_H_SYNC_WIDTH,
    parameter int h_back_porch  = DEF_H_BACK_PORCH,
    parameter int v_active      = DEF_V_ACTIVE,
    parameter int v_front_porch = DEF_V_FRONT_PORCH,
    parameter int v_sync_width  = DEF_V_SYNC_WIDTH,
    parameter int v_back_porch  = DEF_V_BACK_PORCH,
    parameter int sync_polarity = 0
) (
    input  logic        input_clock,
    input  logic        reset,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        data_enable,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_start,
    output logic        line_start
);

    localparam logic sync_on = (sync_polarity != 0);

    phase_t      h_phase, v_phase;
    logic [11:0] h_cnt, v_cnt;
    logic        h_wrap, v_wrap_unused;
    logic        de_next;

    sync_phase_counter #(
        .active_len(h_active), .front_len(h_front_porch),
        .sync_len(h_sync_width), .back_len(h_back_porch)
    ) u_h (
        .input_clock(input_clock), .reset(reset), .advance(enable),
        .phase(h_phase), .count(h_cnt), .wrap(h_wrap)
    );

    // The vertical axis steps once per line, on the cycle that closes H_BACK.
    sync_phase_counter #(
        .active_len(v_active), .front_len(v_front_porch),
        .sync_len(v_sync_width), .back_len(v_back_porch)
    ) u_v (
        .input_clock(input_clock), .reset(reset), .advance(h_wrap),
        .phase(v_phase), .count(v_cnt), .wrap(v_wrap_unused)
    );

    assign de_next = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

    // Counters point at the pixel to present on the next enabled edge, so outputs are a
    // registered decode of the current position.
    always_ff @(posedge input_clock) begin
        if (!reset) begin
            hsync       <= ~sync_on;
            vsync       <= ~sync_on;
            data_enable <= 1'b0;
            pixel_x     <= 12'd0;
            pixel_y     <= 12'd0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else if (enable) begin
            hsync       <= (h_phase == PH_SYNC) ? sync_on : ~sync_on;
            vsync       <= (v_phase == PH_SYNC) ? sync_on : ~sync_on;
            data_enable <= de_next;
            pixel_x     <= de_next ? h_cnt : 12'd0;
            pixel_y     <= de_next ? v_cnt : 12'd0;
            line_start  <= de_next && (h_cnt == 12'd0);
            frame_start <= de_next && (h_cnt == 12'd0) && (v_cnt == 12'd0);
        end
    end

endmodule

// File: tb/tb_video_timing_generator.sv
// Scoreboard bench: small-parameter DUTs (both polarities) plus a default-size line check.
module tb_video_timing_generator;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        ls;
    } vt_out_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic rst_d = 1'b0;
    logic en_d  = 1'b0;

    vt_out_t o0, o1, od;

    int checks = 0;
    int errors = 0;
    bit stim_done = 1'b0;
    bit dflt_done = 1'b0;

    vt_out_t exp_q[$];
    vt_out_t last_exp;
    int      pos = 0;

    always #5 clk = ~clk;

    video_timing_generator #(
        .h_active(4), .h_front_porch(1), .h_sync_width(2), .h_back_porch(1),
        .v_active(3), .v_front_porch(1), .v_sync_width(1), .v_back_porch(1),
        .sync_polarity(0)
    ) dut0 (
        .input_clock(clk), .reset(rst), .enable(en),
        .hsync(o0.hs), .vsync(o0.vs), .data_enable(o0.de),
        .pixel_x(o0.x), .pixel_y(o0.y),
        .frame_start(o0.fs), .line_start(o0.ls)
    );

    video_timing_generator #(
        .h_active(4), .h_front_porch(1), .h_sync_width(2), .h_back_porch(1),
        .v_active(3), .v_front_porch(1), .v_sync_width(1), .v_back_porch(1),
        .sync_polarity(1)
    ) dut1 (
        .input_clock(clk), .reset(rst), .enable(en),
        .hsync(o1.hs), .vsync(o1.vs), .data_enable(o1.de),
        .pixel_x(o1.x), .pixel_y(o1.y),
        .frame_start(o1.fs), .line_start(o1.ls)
    );

    video_timing_generator dutd (
        .input_clock(clk), .reset(rst_d), .enable(en_d),
        .hsync(od.hs), .vsync(od.vs), .data_enable(od.de),
        .pixel_x(od.x), .pixel_y(od.y),
        .frame_start(od.fs), .line_start(od.ls)
    );

    // Expected picture for the small geometry: 8-cycle lines, 6-line frames, active-low syncs.
    function automatic vt_out_t pixel_at(input int p);
        vt_out_t r;
        int col, ln;
        col  = p % 8;
        ln   = p / 8;
        r.de = (col < 4) && (ln < 3);
        r.hs = !(col == 5 || col == 6);
        r.vs = !(ln == 4);
        r.x  = r.de ? 12'(col) : 12'd0;
        r.y  = r.de ? 12'(ln) : 12'd0;
        r.ls = r.de && (col == 0);
        r.fs = r.ls && (ln == 0);
        return r;
    endfunction

    task automatic step(input logic r, input logic e);
        vt_out_t ex;
        @(negedge clk);
        rst = r;
        en  = e;
        if (!r) begin
            ex  = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 12'd0, y: 12'd0, fs: 1'b0, ls: 1'b0};
            pos = 0;
        end else if (e) begin
            ex  = pixel_at(pos);
            pos = (pos + 1) % 48;
        end else begin
            ex = last_exp;
        end
        last_exp = ex;
        exp_q.push_back(ex);
    endtask

    // Monitor: every edge after stimulus starts, pop one expectation and compare both polarities.
    initial begin
        vt_out_t ex, ex1;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                ex  = exp_q.pop_front();
                ex1 = ex;
                ex1.hs = ~ex.hs;
                ex1.vs = ~ex.vs;
                checks++;
                if (o0 !== ex) begin
                    errors++;
                    $display("FAIL pol0 t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b",
                             $time, o0.hs, o0.vs, o0.de, o0.x, o0.y, o0.fs, o0.ls,
                             ex.hs, ex.vs, ex.de, ex.x, ex.y, ex.fs, ex.ls);
                end
                checks++;
                if (o1 !== ex1) begin
                    errors++;
                    $display("FAIL pol1 t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b want hs=%b vs=%b de=%b x=%0d y=%0d fs=%b ls=%b",
                             $time, o1.hs, o1.vs, o1.de, o1.x, o1.y, o1.fs, o1.ls,
                             ex1.hs, ex1.vs, ex1.de, ex1.x, ex1.y, ex1.fs, ex1.ls);
                end
            end
        end
    end

    // Default 800-cycle line: 640 DE cycles, 96 hsync-low cycles, second line starts at row 1.
    initial begin
        int de_cnt, hs_cnt, ls_cnt;
        de_cnt = 0; hs_cnt = 0; ls_cnt = 0;
        repeat (3) @(negedge clk);
        rst_d = 1'b1;
        en_d  = 1'b1;
        for (int k = 0; k < 800; k++) begin
            @(posedge clk);
            #1;
            if (od.de) de_cnt++;
            if (!od.hs) hs_cnt++;
            if (od.ls) ls_cnt++;
            if (k == 0) begin
                checks++;
                if (!(od.fs && od.ls && od.de && od.x == 12'd0 && od.y == 12'd0)) begin
                    errors++;
                    $display("FAIL dflt_first got fs=%b ls=%b de=%b x=%0d y=%0d want 1 1 1 0 0",
                             od.fs, od.ls, od.de, od.x, od.y);
                end
            end
            if (k == 639) begin
                checks++;
                if (od.x != 12'd639) begin
                    errors++;
                    $display("FAIL dflt_last_x got %0d want 639", od.x);
                end
            end
        end
        checks++;
        if (de_cnt != 640) begin
            errors++;
            $display("FAIL dflt_de_count got %0d want 640", de_cnt);
        end
        checks++;
        if (hs_cnt != 96) begin
            errors++;
            $display("FAIL dflt_hsync_count got %0d want 96", hs_cnt);
        end
        checks++;
        if (ls_cnt != 1) begin
            errors++;
            $display("FAIL dflt_line_start_count got %0d want 1", ls_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (!(od.ls && !od.fs && od.y == 12'd1 && od.x == 12'd0)) begin
            errors++;
            $display("FAIL dflt_line1 got ls=%b fs=%b x=%0d y=%0d want 1 0 0 1", od.ls, od.fs, od.x, od.y);
        end
        dflt_done = 1'b1;
    end

    initial begin
        // Reset held with enable high: outputs must sit at reset values.
        repeat (3) step(1'b0, 1'b1);
        // Two full frames: lines of 8, frame of 48, frame_start at cycles 0 and 48.
        repeat (96) step(1'b1, 1'b1);
        // Advance to pixel (2,1), freeze for three cycles, then resume at (3,1).
        repeat (11) step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        // Resume through (1,2), then reset mid-frame and restart from (0,0).
        repeat (7) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (10) step(1'b1, 1'b1);
        stim_done = 1'b1;
    end

    initial begin
        int guard;
        guard = 0;
        while (!(stim_done && dflt_done && exp_q.size() == 0) && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        repeat (2) @(posedge clk);
        if (guard >= 5000) begin
            checks++;
            errors++;
            $display("FAIL timeout stim_done=%b dflt_done=%b pending=%0d want all done",
                     stim_done, dflt_done, exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
